// File: rtl/bat_reg_bank_if.sv
// bat_reg_bank_if: bus, ALU-read, count and move signals of the register bank.
// master drives the requests; slave (the bank) drives bus_out/bus_oe, alu_a/alu_b and move_busy/move_done.
interface bat_reg_bank_if #(parameter int WIDTH = 16, parameter int NREGS = 8);
  localparam int SEL_W = $clog2(NREGS);
  logic [WIDTH-1:0] bus_in, bus_out, alu_a, alu_b;
  logic             bus_oe, load, drive, cnt, cnt_dn, move_req, move_busy, move_done;
  logic [SEL_W-1:0] load_sel, drive_sel, cnt_sel, a_sel, b_sel, move_src, move_dst;
  modport master (
    output bus_in, load, load_sel, drive, drive_sel, cnt, cnt_dn, cnt_sel,
           a_sel, b_sel, move_req, move_src, move_dst,
    input  bus_out, bus_oe, alu_a, alu_b, move_busy, move_done
  );
  modport slave (
    input  bus_in, load, load_sel, drive, drive_sel, cnt, cnt_dn, cnt_sel,
           a_sel, b_sel, move_req, move_src, move_dst,
    output bus_out, bus_oe, alu_a, alu_b, move_busy, move_done
  );
endinterface

// File: rtl/bat_reg_bank.sv
// bat_reg_bank: NREGS x WIDTH register bank with bus load/drive, two ALU operand reads,
// optional up/down counting (macro BAT_REG_BANK_COUNT_EN) and a 3-step register move FSM.
// Ports: clk, rst_n (async active-low), bus (bat_reg_bank_if.slave).
module bat_reg_bank #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic           clk,
  input logic           rst_n,
  bat_reg_bank_if.slave bus
);
  localparam int SEL_W = $clog2(NREGS);
  localparam logic [SEL_W:0] N = (SEL_W+1)'(NREGS);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t           st;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] tmp;
  logic [SEL_W-1:0] src, dst;
  logic             busy, done;

  function automatic logic ok(input logic [SEL_W-1:0] s);
    return {1'b0, s} < N;
  endfunction

  function automatic logic [WIDTH-1:0] rd(input logic [SEL_W-1:0] s);
    return ok(s) ? regs[s] : '0;
  endfunction

  assign bus.alu_a     = rd(bus.a_sel);
  assign bus.alu_b     = rd(bus.b_sel);
  assign bus.bus_oe    = bus.drive;
  assign bus.bus_out   = bus.drive ? rd(bus.drive_sel) : '0;
  assign bus.move_busy = busy;
  assign bus.move_done = done;

  // A request naming an out-of-range register is never accepted, so the move is a no-op.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st   <= IDLE;
      src  <= '0;
      dst  <= '0;
      tmp  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else
      case (st)
        IDLE: if (bus.move_req && ok(bus.move_src) && ok(bus.move_dst)) begin
          st   <= FETCH;
          src  <= bus.move_src;
          dst  <= bus.move_dst;
          busy <= 1'b1;
        end
        FETCH: begin
          tmp <= regs[src];
          st  <= WRITE;
        end
        WRITE: begin
          st   <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase

  // Per-register priority: move write, then load, then count. Out-of-range selects match no index.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else
      for (int i = 0; i < NREGS; i++)
        if (st == WRITE && dst == SEL_W'(i)) regs[i] <= tmp;
        else if (bus.load && bus.load_sel == SEL_W'(i)) regs[i] <= bus.bus_in;
`ifdef BAT_REG_BANK_COUNT_EN
        else if (bus.cnt && bus.cnt_sel == SEL_W'(i))
          regs[i] <= bus.cnt_dn ? regs[i] - WIDTH'(1) : regs[i] + WIDTH'(1);
`endif

`ifndef BAT_REG_BANK_COUNT_EN
  logic unused_cnt;
  assign unused_cnt = ^{bus.cnt, bus.cnt_dn, bus.cnt_sel};
`endif
endmodule

// File: tb/tb_bat_reg_bank.sv
// tb_bat_reg_bank: randomized + directed scoreboard bench for bat_reg_bank (NREGS=6 to reach out-of-range selects).
module tb_bat_reg_bank;
  localparam int W  = 16;
  localparam int NR = 6;
  localparam int SW = $clog2(NR);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bat_reg_bank_if #(.WIDTH(W), .NREGS(NR)) bus ();
  bat_reg_bank #(.WIDTH(W), .NREGS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] mdl [NR];
  logic [W-1:0] sb [$];
  int phase = 0;
  int msrc = 0;
  int mdst = 0;
  logic [W-1:0] mv_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mrd(input logic [SW-1:0] s);
    return (int'(s) < NR) ? mdl[s] : '0;
  endfunction

  task automatic clear();
    bus.bus_in = '0; bus.load = 0; bus.load_sel = '0; bus.drive = 0; bus.drive_sel = '0;
    bus.cnt = 0; bus.cnt_dn = 0; bus.cnt_sel = '0; bus.a_sel = '0; bus.b_sel = '0;
    bus.move_req = 0; bus.move_src = '0; bus.move_dst = '0;
  endtask

  // Checks this cycle's outputs, queues the expected read, then applies the edge to the model.
  task automatic tick();
    logic [W-1:0] old [NR];
    #1;
    chk("alu_a", 32'(bus.alu_a), 32'(mrd(bus.a_sel)));
    chk("alu_b", 32'(bus.alu_b), 32'(mrd(bus.b_sel)));
    chk("bus_oe", 32'(bus.bus_oe), 32'(bus.drive));
    if (!bus.drive) chk("bus_out_idle", 32'(bus.bus_out), 32'd0);
    chk("move_busy", 32'(bus.move_busy), 32'(phase != 0));
    chk("move_done", 32'(bus.move_done), 32'(phase == 3));
    if (bus.drive) sb.push_back(mrd(bus.drive_sel));
    old = mdl;
`ifdef BAT_REG_BANK_COUNT_EN
    if (bus.cnt && int'(bus.cnt_sel) < NR)
      mdl[bus.cnt_sel] = bus.cnt_dn ? old[bus.cnt_sel] - 16'd1 : old[bus.cnt_sel] + 16'd1;
`endif
    if (bus.load && int'(bus.load_sel) < NR) mdl[bus.load_sel] = bus.bus_in;
    if (phase == 2) mdl[mdst] = mv_val;
    case (phase)
      0: if (bus.move_req && int'(bus.move_src) < NR && int'(bus.move_dst) < NR) begin
        phase = 1; msrc = int'(bus.move_src); mdst = int'(bus.move_dst);
      end
      1: begin mv_val = old[msrc]; phase = 2; end
      2: phase = 3;
      default: phase = 0;
    endcase
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    phase = 0;
    bus.a_sel = SW'(2); bus.b_sel = SW'(5);
    #1;
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_busy", 32'(bus.move_busy), 32'd0);
    chk("rst_done", 32'(bus.move_done), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_done_hold", 32'(bus.move_done), 32'd0);
    end
    rst_n = 1'b1;
    clear();
  endtask

  task automatic read(input int s);
    bus.drive = 1; bus.drive_sel = SW'(s); bus.a_sel = SW'(s); bus.b_sel = SW'(7 - s);
    tick();
  endtask

  task automatic load(input int s, input logic [W-1:0] d);
    bus.load = 1; bus.load_sel = SW'(s); bus.bus_in = d;
    tick();
  endtask

  always @(negedge clk)
    if (rst_n && bus.bus_oe) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_underflow: bus_oe high with no expected read at %0t", $time);
      end else chk("bus_out", 32'(bus.bus_out), 32'(sb.pop_front()));
    end

  initial begin
    clear();
    #2;
    apply_reset();
    for (int s = 0; s < 8; s++) read(s);
    // load / readback
    load(3, 16'hBEEF);
    read(3);
    // wrap (count logic only present with the macro; the model follows the same build)
    load(1, 16'hFFFF);
    bus.cnt = 1; bus.cnt_sel = SW'(1); tick();
    read(1);
    bus.cnt = 1; bus.cnt_dn = 1; bus.cnt_sel = SW'(1); tick();
    read(1);
    load(0, 16'h0000);
    bus.cnt = 1; bus.cnt_dn = 1; bus.cnt_sel = SW'(0); tick();
    read(0);
    // move 2->5 with a second request while busy
    load(2, 16'h1234);
    bus.move_req = 1; bus.move_src = SW'(2); bus.move_dst = SW'(5); tick();
    bus.move_req = 1; bus.move_src = SW'(3); bus.move_dst = SW'(4); bus.drive = 1; bus.drive_sel = SW'(3); tick();
    bus.a_sel = SW'(2); tick();
    tick();
    read(5); read(2); read(4);
    // collision on the write edge, plus a load to SRC after fetch
    load(2, 16'h5A5A);
    bus.move_req = 1; bus.move_src = SW'(2); bus.move_dst = SW'(5); tick();
    tick();
    bus.load = 1; bus.load_sel = SW'(5); bus.bus_in = 16'hAAAA;
    bus.cnt = 1; bus.cnt_sel = SW'(5); tick();
    tick();
    read(5);
    bus.move_req = 1; bus.move_src = SW'(3); bus.move_dst = SW'(1); tick();
    load(3, 16'h0F0F);
    tick(); tick();
    read(1); read(3);
    // SRC == DST
    bus.move_req = 1; bus.move_src = SW'(4); bus.move_dst = SW'(4); tick();
    tick(); tick(); tick();
    read(4);
    // abort during WRITE
    load(2, 16'h7777);
    bus.move_req = 1; bus.move_src = SW'(2); bus.move_dst = SW'(5); tick();
    tick();
    apply_reset();
    read(5); read(2);
    tick(); tick();
    // out of range
    load(1, 16'h1111);
    load(7, 16'h5555);
    load(6, 16'h6666);
    for (int s = 0; s < 8; s++) read(s);
    bus.move_req = 1; bus.move_src = SW'(7); bus.move_dst = SW'(1); tick();
    tick();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 3));
      bus.bus_in = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : W'($urandom);
      bus.load = ($urandom_range(0, 2) == 0);
      bus.load_sel = SW'($urandom_range(0, 7));
      bus.cnt = ($urandom_range(0, 1) == 1);
      bus.cnt_dn = ($urandom_range(0, 1) == 1);
      bus.cnt_sel = SW'($urandom_range(0, 7));
      bus.drive = ($urandom_range(0, 1) == 1);
      bus.drive_sel = SW'($urandom_range(0, 7));
      bus.a_sel = SW'($urandom_range(0, 7));
      bus.b_sel = SW'($urandom_range(0, 7));
      bus.move_req = ($urandom_range(0, 5) == 0);
      bus.move_src = SW'($urandom_range(0, 7));
      bus.move_dst = SW'($urandom_range(0, 7));
      tick();
    end
    repeat (4) tick();
    for (int s = 0; s < NR; s++) read(s);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bat_reg_bank.md
BAT_REG_BANK -- requirements
Module: bat_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register and bus width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of registers (2..16); SEL_W = clog2(NREGS).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 BUS_IN  in  WIDTH  write data from the system bus.
REQ-006 BUS_OUT  out  WIDTH  read data toward the bus; the top level owns the tristate.
REQ-007 BUS_OE  out  1  high when BUS_OUT is valid and must be driven.
REQ-008 LOAD / LOAD_SEL  in  1 / SEL_W  write BUS_IN into register LOAD_SEL.
REQ-009 DRIVE / DRIVE_SEL  in  1 / SEL_W  place register DRIVE_SEL on BUS_OUT.
REQ-010 CNT / CNT_DN / CNT_SEL  in  1 / 1 / SEL_W  increment (CNT_DN=0) or decrement (CNT_DN=1) register CNT_SEL.
REQ-011 A_SEL, B_SEL  in  SEL_W each  ALU operand selects.
REQ-012 ALU_A, ALU_B  out  WIDTH each  ALU operand outputs.
REQ-013 MOVE_REQ / MOVE_SRC / MOVE_DST  in  1 / SEL_W / SEL_W  request an internal register-to-register copy.
REQ-014 MOVE_BUSY  out  1  high while a move is in progress.
REQ-015 MOVE_DONE  out  1  single-cycle pulse when a move completes.

Function
REQ-016 ALU_A and ALU_B SHALL be combinational reads of reg[A_SEL] and reg[B_SEL], with zero added latency.
REQ-017 BUS_OE SHALL equal DRIVE, combinationally; BUS_OUT SHALL be reg[DRIVE_SEL] when DRIVE=1, else all zeros.
REQ-018 LOAD SHALL write BUS_IN into reg[LOAD_SEL] at the next edge; readback SHALL be visible 1 cycle later.
REQ-019 CNT SHALL apply modulo 2^WIDTH: all-ones +1 wraps to 0, and 0 -1 wraps to all-ones.
REQ-020 Any select value >= NREGS SHALL make LOAD, CNT, and moves no-ops, and SHALL make reads return zero.
REQ-021 The move FSM SHALL have the states IDLE, FETCH, WRITE, and DONE.
REQ-022 IDLE -> FETCH SHALL occur on MOVE_REQ=1; SRC and DST SHALL be captured on that edge.
REQ-023 FETCH -> WRITE SHALL latch reg[SRC] into an internal temporary register.
REQ-024 WRITE -> DONE SHALL write the temporary register into reg[DST].
REQ-025 DONE -> IDLE SHALL be unconditional, with MOVE_DONE=1 for that cycle only.
REQ-026 MOVE_BUSY SHALL be 1 in FETCH, WRITE, and DONE; a move SHALL take 3 cycles from the request edge to MOVE_DONE.
REQ-027 MOVE_REQ while MOVE_BUSY=1 SHALL be ignored, not queued.
REQ-028 The temporary register SHALL hold the value present at the FETCH edge; a later LOAD to SRC SHALL NOT affect the moved value.
REQ-029 Same-register same-edge write priority SHALL be, highest first: move WRITE, then LOAD, then CNT; the lower-priority operations SHALL be dropped.
REQ-030 Writes to different registers on the same edge SHALL all take effect.
REQ-031 A move with SRC == DST SHALL complete normally and leave the value unchanged.
REQ-032 DRIVE and ALU reads SHALL remain operative during a move.

Reset
REQ-033 RST=0 SHALL immediately, without waiting for a clock edge, set:
- all registers and the temporary register to 0;
- the FSM to IDLE;
- MOVE_BUSY=0 and MOVE_DONE=0.
REQ-034 Reset asserted mid-move SHALL abort the move; no write to DST SHALL occur and MOVE_DONE SHALL NOT pulse.
REQ-035 After RST deasserts, the first rising edge SHALL accept operations.

Configuration
REQ-036 When macro BAT_REG_BANK_COUNT_EN is defined, the counting logic of REQ-010 and REQ-019 SHALL be present.
REQ-037 When BAT_REG_BANK_COUNT_EN is undefined, CNT, CNT_DN, and CNT_SEL SHALL be ignored and no incrementer/decrementer logic SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-038 Load/read: reset; LOAD reg3=16'hBEEF; next cycle DRIVE_SEL=3 -> BUS_OE=1, BUS_OUT=16'hBEEF; ALU_A with A_SEL=3 -> 16'hBEEF.
REQ-039 Wrap (COUNT_EN defined): reg1=16'hFFFF, CNT up -> 16'h0000; CNT down -> 16'hFFFF.
REQ-040 Move: reg2=16'h1234, MOVE 2->5 -> MOVE_BUSY high for 3 cycles, MOVE_DONE pulses once, reg5=16'h1234, reg2 unchanged; a second MOVE_REQ while busy -> no effect.
REQ-041 Collision: on the WRITE edge of a move to reg5, LOAD reg5=16'hAAAA plus CNT reg5 -> reg5 equals the moved value.
REQ-042 Abort: MOVE 2->5 with RST=0 asserted during WRITE -> reg5=0, MOVE_BUSY=0, no MOVE_DONE pulse.
REQ-043 Out-of-range (NREGS=6): LOAD_SEL=7 -> no register changes; DRIVE_SEL=7 -> BUS_OUT=0.
